// File: rtl/systolic_result_drain.sv
// Snapshots the systolic array's C matrix on output_ready, requantizes each element and streams it row-major.
// Optional rounding before the shift: define SYSTOLIC_DRAIN_ROUND_EN.
module systolic_result_drain #(
  parameter int BIT_WIDTH = 5,
  parameter int A_ROW     = 2,
  parameter int B_COL     = 2,
  parameter int ACC_WIDTH = BIT_WIDTH << 1,
  parameter int OUT_WIDTH = BIT_WIDTH,
  parameter int SHIFT     = 0,
  localparam int ROW_W    = ($clog2(A_ROW) > 0) ? $clog2(A_ROW) : 1,
  localparam int COL_W    = ($clog2(B_COL) > 0) ? $clog2(B_COL) : 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               mm_ready,
  input  logic [A_ROW*B_COL*ACC_WIDTH-1:0]   mm_C,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [OUT_WIDTH-1:0]               out_data,
  output logic [ROW_W-1:0]                   out_row,
  output logic [COL_W-1:0]                   out_col,
  output logic                               out_last,
  output logic                               out_sat,
  output logic                               busy,
  output logic                               overrun,
  input  logic                               overrun_clr
);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(A_ROW - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(B_COL - 1);
  localparam logic             SINGLE   = (A_ROW * B_COL == 1);

  localparam logic signed [ACC_WIDTH:0] Q_MAX =
    {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] Q_MIN = ~Q_MAX;

`ifdef SYSTOLIC_DRAIN_ROUND_EN
  localparam logic [ACC_WIDTH:0]        RND_ONE = {{ACC_WIDTH{1'b0}}, 1'b1};
  // Half an LSB of the shifted result; zero when SHIFT==0 so rounding is a no-op.
  localparam logic signed [ACC_WIDTH:0] RND     = (RND_ONE << SHIFT) >> 1;
`endif

  // Returns {sat, data}.
  function automatic logic [OUT_WIDTH:0] requant(input logic [ACC_WIDTH-1:0] e);
    logic signed [ACC_WIDTH:0] t;
    t = signed'({e[ACC_WIDTH-1], e});
`ifdef SYSTOLIC_DRAIN_ROUND_EN
    t = t + RND;
`endif
    t = t >>> SHIFT;
    if (t > Q_MAX)      requant = {1'b1, Q_MAX[OUT_WIDTH-1:0]};
    else if (t < Q_MIN) requant = {1'b1, Q_MIN[OUT_WIDTH-1:0]};
    else                requant = {1'b0, t[OUT_WIDTH-1:0]};
  endfunction

  state_t                             r_state;
  state_t                             w_state_nxt;
  logic                               r_mm_ready_q;
  logic [A_ROW*B_COL*ACC_WIDTH-1:0]   r_snap;
  logic [ROW_W-1:0]                   r_row;
  logic [COL_W-1:0]                   r_col;
  logic [OUT_WIDTH-1:0]               r_data;
  logic                               r_last;
  logic                               r_sat;
  logic                               r_overrun;

  logic                               w_stream;
  logic                               w_start;
  logic                               w_xfer;
  logic                               w_end;
  logic                               w_capture;
  logic                               w_drop;
  logic [ROW_W-1:0]                   w_next_row;
  logic [COL_W-1:0]                   w_next_col;
  logic                               w_next_last;
  logic [ACC_WIDTH-1:0]               w_next_elem;
  logic [OUT_WIDTH:0]                 w_q_first;
  logic [OUT_WIDTH:0]                 w_q_next;

  always_comb begin
    w_stream  = (r_state == S_STREAM);
    w_start   = mm_ready & ~r_mm_ready_q;
    w_xfer    = w_stream & out_ready;
    w_end     = w_xfer & r_last;
    // A start coinciding with the final transfer is a clean back-to-back capture.
    w_capture = w_start & (~w_stream | w_end);
    w_drop    = w_start & w_stream & ~w_end;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_start) w_state_nxt = S_STREAM;
      S_STREAM: if (w_end && !w_start) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    out_valid = (r_state == S_STREAM);
    busy      = (r_state == S_STREAM);
    out_data  = r_data;
    out_row   = r_row;
    out_col   = r_col;
    out_last  = r_last;
    out_sat   = r_sat;
    overrun   = r_overrun;
  end

  always_comb begin
    w_next_row = r_row;
    w_next_col = r_col + 1'b1;
    if (r_col == COL_LAST) begin
      w_next_col = '0;
      w_next_row = r_row + 1'b1;
    end
    w_next_last = (w_next_row == ROW_LAST) && (w_next_col == COL_LAST);
    w_next_elem = '0;
    for (int unsigned r = 0; r < A_ROW; r++) begin
      for (int unsigned c = 0; c < B_COL; c++) begin
        if (w_next_row == ROW_W'(r) && w_next_col == COL_W'(c)) begin
          w_next_elem = r_snap[(r*B_COL + c)*ACC_WIDTH +: ACC_WIDTH];
        end
      end
    end
    w_q_first = requant(mm_C[ACC_WIDTH-1:0]);
    w_q_next  = requant(w_next_elem);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mm_ready_q <= 1'b0;
      r_snap       <= '0;
      r_row        <= '0;
      r_col        <= '0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_sat        <= 1'b0;
    end else begin
      r_mm_ready_q <= mm_ready;
      if (w_capture) begin
        r_snap <= mm_C;
        r_row  <= '0;
        r_col  <= '0;
        r_data <= w_q_first[OUT_WIDTH-1:0];
        r_sat  <= w_q_first[OUT_WIDTH];
        r_last <= SINGLE;
      end else if (w_xfer && !r_last) begin
        r_row  <= w_next_row;
        r_col  <= w_next_col;
        r_data <= w_q_next[OUT_WIDTH-1:0];
        r_sat  <= w_q_next[OUT_WIDTH];
        r_last <= w_next_last;
      end else if (w_end) begin
        r_row  <= '0;
        r_col  <= '0;
        r_data <= '0;
        r_sat  <= 1'b0;
        r_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (w_drop) begin
      r_overrun <= 1'b1;
    end else if (overrun_clr) begin
      r_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: SHIFT=0 instance for streaming/control, SHIFT=2 instance for requant.
module tb_systolic_result_drain;

  localparam int AW = 10;

`ifdef SYSTOLIC_DRAIN_ROUND_EN
  localparam int SH2_E00 = 2;
  localparam int SH2_E01 = -1;
`else
  localparam int SH2_E00 = 1;
  localparam int SH2_E01 = -2;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          mm_ready;
  logic [4*AW-1:0] mm_C;
  logic          out_ready;
  logic          overrun_clr;

  logic          o0_valid, o0_last, o0_sat, o0_busy, o0_overrun;
  logic [4:0]    o0_data;
  logic          o0_row, o0_col;
  logic          o2_valid, o2_last, o2_sat, o2_busy, o2_overrun;
  logic [4:0]    o2_data;
  logic          o2_row, o2_col;

  int n_checks = 0;
  int n_errors = 0;

  int exp_d[4] = '{3, -4, 15, -16};
  int exp_s[4] = '{0, 0, 1, 1};

  always #5 clk = ~clk;

  systolic_result_drain #(.BIT_WIDTH(5), .A_ROW(2), .B_COL(2), .SHIFT(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .mm_ready(mm_ready), .mm_C(mm_C),
    .out_valid(o0_valid), .out_ready(out_ready), .out_data(o0_data),
    .out_row(o0_row), .out_col(o0_col), .out_last(o0_last), .out_sat(o0_sat),
    .busy(o0_busy), .overrun(o0_overrun), .overrun_clr(overrun_clr)
  );

  systolic_result_drain #(.BIT_WIDTH(5), .A_ROW(2), .B_COL(2), .SHIFT(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .mm_ready(mm_ready), .mm_C(mm_C),
    .out_valid(o2_valid), .out_ready(out_ready), .out_data(o2_data),
    .out_row(o2_row), .out_col(o2_col), .out_last(o2_last), .out_sat(o2_sat),
    .busy(o2_busy), .overrun(o2_overrun), .overrun_clr(overrun_clr)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4*AW-1:0] pack4(input int c00, input int c01,
                                            input int c10, input int c11);
    logic [AW-1:0] a, b, c, d;
    a = AW'(c00); b = AW'(c01); c = AW'(c10); d = AW'(c11);
    return {d, c, b, a};
  endfunction

  task automatic chk_elem0(input string tag, input int k, input int d, input int s);
    check({tag, "_valid"}, o0_valid, 1);
    check({tag, "_data"},  $signed(o0_data), d);
    check({tag, "_row"},   o0_row, k / 2);
    check({tag, "_col"},   o0_col, k % 2);
    check({tag, "_last"},  o0_last, (k == 3) ? 1 : 0);
    check({tag, "_sat"},   o0_sat, s);
  endtask

  task automatic chk_all_zero(input string tag);
    check({tag, "_valid"},   o0_valid, 0);
    check({tag, "_data"},    o0_data, 0);
    check({tag, "_row"},     o0_row, 0);
    check({tag, "_col"},     o0_col, 0);
    check({tag, "_last"},    o0_last, 0);
    check({tag, "_sat"},     o0_sat, 0);
    check({tag, "_busy"},    o0_busy, 0);
    check({tag, "_overrun"}, o0_overrun, 0);
  endtask

  initial begin
    int idx;
    int xfers;
    reset_n     = 1'b0;
    mm_ready    = 1'b0;
    mm_C        = '0;
    out_ready   = 1'b0;
    overrun_clr = 1'b0;
    tick;
    tick;
    chk_all_zero("rst");
    reset_n = 1'b1;
    tick;

    // 1: streaming at full throughput, long mm_ready level
    mm_C      = pack4(3, -4, 20, -20);
    mm_ready  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      chk_elem0("t1", k, exp_d[k], exp_s[k]);
    end
    tick;
    check("t1_idle_valid", o0_valid, 0);
    check("t1_idle_busy",  o0_busy, 0);
    for (int k = 0; k < 3; k++) begin
      tick;
      check("t1_one_stream", o0_valid, 0);
    end
    mm_ready = 1'b0;
    tick;

    // 2: backpressure, out_ready toggling
    mm_ready  = 1'b1;
    out_ready = 1'b0;
    tick;
    idx   = 0;
    xfers = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      out_ready = ((cyc % 2) == 1);
      if (o0_valid) begin
        if (idx < 4) chk_elem0("t2", idx, exp_d[idx], exp_s[idx]);
        else         check("t2_extra_valid", o0_valid, 0);
        if (out_ready) begin
          xfers++;
          idx++;
        end
      end
      tick;
    end
    check("t2_xfers", xfers, 4);
    check("t2_busy",  o0_busy, 0);
    mm_ready  = 1'b0;
    out_ready = 1'b0;
    tick;

    // 3: shifted requant on the SHIFT=2 instance
    mm_C     = pack4(6, -6, 0, 0);
    mm_ready = 1'b1;
    tick;
    check("t3_sh2_e00", $signed(o2_data), SH2_E00);
    check("t3_sh0_e00", $signed(o0_data), 6);
    out_ready = 1'b1;
    tick;
    check("t3_sh2_e01", $signed(o2_data), SH2_E01);
    check("t3_sh0_e01", $signed(o0_data), -6);
    check("t3_sh2_sat", o2_sat, 0);
    tick;
    tick;
    tick;
    check("t3_busy0", o0_busy, 0);
    check("t3_busy2", o2_busy, 0);
    mm_ready  = 1'b0;
    out_ready = 1'b0;
    tick;

    // 4: overrun while stalled, set-wins-over-clear, then clear
    mm_C     = pack4(3, -4, 20, -20);
    mm_ready = 1'b1;
    tick;
    mm_ready = 1'b0;
    tick;
    check("t4_ovr_pre", o0_overrun, 0);
    mm_C     = pack4(1, 2, 3, 4);
    mm_ready = 1'b1;
    tick;
    check("t4_ovr_set", o0_overrun, 1);
    chk_elem0("t4_hold", 0, 3, 0);
    mm_ready = 1'b0;
    tick;
    mm_ready    = 1'b1;
    overrun_clr = 1'b1;
    tick;
    check("t4_set_wins", o0_overrun, 1);
    mm_ready = 1'b0;
    tick;
    check("t4_cleared", o0_overrun, 0);
    overrun_clr = 1'b0;
    chk_elem0("t4", 0, exp_d[0], exp_s[0]);
    out_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick;
      chk_elem0("t4", k, exp_d[k], exp_s[k]);
    end
    tick;
    check("t4_busy", o0_busy, 0);

    // 5: back-to-back start on the final transfer
    mm_C     = pack4(3, -4, 20, -20);
    mm_ready = 1'b1;
    tick;
    mm_ready = 1'b0;
    for (int k = 1; k < 4; k++) tick;
    chk_elem0("t5_a", 3, exp_d[3], exp_s[3]);
    mm_C     = pack4(-1, 7, 0, 5);
    mm_ready = 1'b1;
    tick;
    chk_elem0("t5_b", 0, -1, 0);
    check("t5_overrun", o0_overrun, 0);
    check("t5_busy",    o0_busy, 1);
    mm_ready = 1'b0;
    tick;
    chk_elem0("t5_b", 1, 7, 0);
    tick;
    chk_elem0("t5_b", 2, 0, 0);
    tick;
    chk_elem0("t5_b", 3, 5, 0);
    tick;
    check("t5_idle", o0_valid, 0);

    // 6: asynchronous reset mid-stream, restart from held mm_ready
    mm_C     = pack4(3, -4, 20, -20);
    mm_ready = 1'b1;
    tick;
    tick;
    tick;
    chk_elem0("t6_pre", 2, 15, 1);
    reset_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    tick;
    reset_n = 1'b1;
    tick;
    chk_elem0("t6_restart", 0, 3, 0);
    tick;
    chk_elem0("t6_restart", 1, -4, 0);
    mm_ready = 1'b0;
    tick;
    tick;
    tick;
    check("t6_done", o0_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
